// File: rtl/spi_frame_sequencer.sv
// SPI mode-0 peripheral front end: synchronises the pins, detects edges, and turns
// RW/address/data frames into register strobes. Optional error counter: SPI_ERR_CNT_EN.
module spi_frame_sequencer #(
  parameter int ADDR_W      = 3,
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              ena,
  input  logic              spi_cs_n,
  input  logic              spi_sclk,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_wdata,
  output logic              reg_we,
  output logic              reg_re,
  input  logic [DATA_W-1:0] reg_rdata,
  output logic              frame_err,
`ifdef SPI_ERR_CNT_EN
  output logic [7:0]        err_cnt,
`endif
  output logic              busy
);

  localparam int MAX_W = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int CNT_W = $clog2(MAX_W) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RW,
    S_ADDR,
    S_DATA,
    S_DONE
  } state_t;

  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic                   r_cs_dly;
  logic                   r_sclk_dly;

  state_t                 r_state;
  logic [CNT_W-1:0]       r_bit_cnt;
  logic                   r_rw;
  logic                   r_rise_seen;
  logic [ADDR_W-1:0]      r_addr;
  logic [DATA_W-1:0]      r_wsr;
  logic [DATA_W-1:0]      r_wdata;
  logic [DATA_W-1:0]      r_miso_sr;
  logic                   r_we;
  logic                   r_re;
  logic                   r_err;

  state_t                 w_state_next;
  logic [CNT_W-1:0]       w_bit_cnt_next;
  logic                   w_rw_next;
  logic                   w_rise_seen_next;
  logic [ADDR_W-1:0]      w_addr_next;
  logic [DATA_W-1:0]      w_wsr_next;
  logic [DATA_W-1:0]      w_wdata_next;
  logic [DATA_W-1:0]      w_miso_sr_next;
  logic                   w_we_next;
  logic                   w_re_next;
  logic                   w_err_next;

  logic w_cs;
  logic w_sclk;
  logic w_mosi;
  logic w_cs_rise;
  logic w_cs_fall;
  logic w_sclk_rise;
  logic w_sclk_fall;

  // cs_n synchronises to its inactive level so reset never looks like a frame start.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_cs_sync   <= '1;
      r_sclk_sync <= '0;
      r_mosi_sync <= '0;
    end else begin
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], spi_cs_n};
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], spi_sclk};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi};
    end
  end

  assign w_cs   = r_cs_sync[SYNC_STAGES-1];
  assign w_sclk = r_sclk_sync[SYNC_STAGES-1];
  assign w_mosi = r_mosi_sync[SYNC_STAGES-1];

  // Frozen delay flops keep a level change pending until ena returns.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_cs_dly   <= 1'b1;
      r_sclk_dly <= 1'b0;
    end else if (ena) begin
      r_cs_dly   <= w_cs;
      r_sclk_dly <= w_sclk;
    end
  end

  assign w_cs_rise   = ena &  w_cs & ~r_cs_dly;
  assign w_cs_fall   = ena & ~w_cs &  r_cs_dly;
  // A chip-select edge discards any coincident sclk edge.
  assign w_sclk_rise = ena &  w_sclk & ~r_sclk_dly & ~(w_cs_rise | w_cs_fall);
  assign w_sclk_fall = ena & ~w_sclk &  r_sclk_dly & ~(w_cs_rise | w_cs_fall);

  always_comb begin
    w_state_next     = r_state;
    w_bit_cnt_next   = r_bit_cnt;
    w_rw_next        = r_rw;
    w_rise_seen_next = r_rise_seen;
    w_addr_next      = r_addr;
    w_wsr_next       = r_wsr;
    w_wdata_next     = r_wdata;
    w_we_next        = 1'b0;
    w_re_next        = 1'b0;
    w_err_next       = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_cs_fall) begin
          w_state_next = S_RW;
        end
      end
      S_RW: begin
        if (w_cs_rise) begin
          w_state_next = S_IDLE;
          w_err_next   = 1'b1;
        end else if (w_sclk_rise) begin
          w_rw_next      = w_mosi;
          w_bit_cnt_next = '0;
          w_state_next   = S_ADDR;
        end
      end
      S_ADDR: begin
        if (w_cs_rise) begin
          w_state_next = S_IDLE;
          w_err_next   = 1'b1;
        end else if (w_sclk_rise) begin
          w_addr_next = (r_addr << 1) | ADDR_W'(w_mosi);
          if (r_bit_cnt == CNT_W'(ADDR_W - 1)) begin
            w_state_next     = S_DATA;
            w_bit_cnt_next   = '0;
            w_rise_seen_next = 1'b0;
            w_re_next        = ~r_rw;
          end else begin
            w_bit_cnt_next = r_bit_cnt + CNT_W'(1);
          end
        end
      end
      S_DATA: begin
        if (w_cs_rise) begin
          w_state_next = S_IDLE;
          w_err_next   = 1'b1;
        end else if (w_sclk_rise) begin
          w_rise_seen_next = 1'b1;
          w_wsr_next       = (r_wsr << 1) | DATA_W'(w_mosi);
          if (r_bit_cnt == CNT_W'(DATA_W - 1)) begin
            w_state_next = S_DONE;
            if (r_rw) begin
              w_wdata_next = w_wsr_next;
              w_we_next    = 1'b1;
            end
          end else begin
            w_bit_cnt_next = r_bit_cnt + CNT_W'(1);
          end
        end
      end
      S_DONE: begin
        if (w_cs_rise) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Read data is captured while reg_re is high; the first fall after the strobe
  // precedes any DATA rise, so the MSB stays on the line for the first sample.
  always_comb begin
    w_miso_sr_next = r_miso_sr;
    if (r_re) begin
      w_miso_sr_next = reg_rdata;
    end else if ((r_state == S_DATA) && !r_rw && r_rise_seen && w_sclk_fall) begin
      w_miso_sr_next = r_miso_sr << 1;
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_state     <= S_IDLE;
      r_bit_cnt   <= '0;
      r_rw        <= 1'b0;
      r_rise_seen <= 1'b0;
      r_addr      <= '0;
      r_wsr       <= '0;
      r_wdata     <= '0;
      r_miso_sr   <= '0;
      r_we        <= 1'b0;
      r_re        <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_bit_cnt   <= w_bit_cnt_next;
      r_rw        <= w_rw_next;
      r_rise_seen <= w_rise_seen_next;
      r_addr      <= w_addr_next;
      r_wsr       <= w_wsr_next;
      r_wdata     <= w_wdata_next;
      r_miso_sr   <= w_miso_sr_next;
      r_we        <= w_we_next;
      r_re        <= w_re_next;
      r_err       <= w_err_next;
    end
  end

`ifdef SPI_ERR_CNT_EN
  logic [7:0] r_err_cnt;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_err_cnt <= '0;
    end else if (w_err_next && (r_err_cnt != 8'hFF)) begin
      r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign err_cnt = r_err_cnt;
`endif

  assign spi_miso_oe = (r_state == S_DATA) && !r_rw;
  assign spi_miso    = spi_miso_oe & r_miso_sr[DATA_W-1];
  assign reg_addr    = r_addr;
  assign reg_wdata   = r_wdata;
  assign reg_we      = r_we;
  assign reg_re      = r_re;
  assign frame_err   = r_err;
  assign busy        = (r_state != S_IDLE);

endmodule
